// File: rtl/vga_sprite_pkg.sv
// Shared scan codes, prefix-FSM states and move helpers for the sprite path.
// Saturating arithmetic widens to 11 bits internally.
package vga_sprite_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;

  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } ps2_state_e;

  typedef enum logic [2:0] {
    MV_NONE,
    MV_LEFT,
    MV_RIGHT,
    MV_UP,
    MV_DOWN
  } move_e;

  function automatic move_e plain_move(
    input logic [7:0] b
  );
    case (b)
      SC_A:    return MV_LEFT;
      SC_D:    return MV_RIGHT;
      SC_W:    return MV_UP;
      SC_S:    return MV_DOWN;
      default: return MV_NONE;
    endcase
  endfunction

  function automatic move_e arrow_move(
    input logic [7:0] b
  );
    case (b)
      SC_LEFT:  return MV_LEFT;
      SC_RIGHT: return MV_RIGHT;
      SC_UP:    return MV_UP;
      SC_DOWN:  return MV_DOWN;
      default:  return MV_NONE;
    endcase
  endfunction

  function automatic logic [9:0] sat_sub(
    input logic [9:0] v,
    input logic [9:0] s
  );
    return (v < s) ? 10'd0 : v - s;
  endfunction

  function automatic logic [9:0] sat_add(
    input logic [9:0] v,
    input logic [9:0] s,
    input logic [9:0] lim
  );
    logic [10:0] sum;
    sum = {1'b0, v} + {1'b0, s};
    return (sum > {1'b0, lim}) ? lim : sum[9:0];
  endfunction

endpackage

// File: rtl/ps2_strobe_sync.sv
// Brings the PS/2 byte strobe into the pixel clock domain.
// Emits a single-cycle pulse on each rising edge of the strobe.
module ps2_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic pulse
);

  logic s1;
  logic s2;
  logic s3;

  // Two-flop synchronizer followed by an edge-history flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= strobe;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign pulse = s2 & ~s3;

endmodule

// File: rtl/ps2_sprite_mover.sv
// Decodes PS/2 make codes into a clamped sprite position, committed at vsync.
// Define ARROW_KEYS_EN to let E0-prefixed arrow keys move the sprite too.
module ps2_sprite_mover
  import vga_sprite_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int SPRITE_W = 30,
  parameter int SPRITE_H = 30,
  parameter int STEP     = 15,
  parameter int X_INIT   = 340,
  parameter int Y_INIT   = 200
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic       ps2_key_pressed,
  input  logic [7:0] ps2_out,
  input  logic       iVS,
  output logic [9:0] oX,
  output logic [9:0] oY,
  output logic       oUpdate
);

  localparam logic [9:0] XMAX  = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0] YMAX  = 10'(V_ACTIVE - SPRITE_H);
  localparam logic [9:0] STP   = 10'(STEP);
  localparam logic [9:0] XINIT = 10'(X_INIT);
  localparam logic [9:0] YINIT = 10'(Y_INIT);

  logic       byte_vld;
  ps2_state_e state;
  ps2_state_e state_nxt;
  move_e      move;
  logic [9:0] sx;
  logic [9:0] sy;
  logic       vs_q;
  logic       vs_fall;

  ps2_strobe_sync u_sync (
    .clk    (iVGA_CLK),
    .rst_n  (iRST_n),
    .strobe (ps2_key_pressed),
    .pulse  (byte_vld)
  );

  // Prefix tracking; a move is only raised for make codes.
  always_comb begin
    state_nxt = state;
    move      = MV_NONE;
    if (byte_vld) begin
      unique case (state)
        IDLE: begin
          if (ps2_out == SC_EXT)
            state_nxt = EXT;
          else if (ps2_out == SC_BRK)
            state_nxt = BRK;
          else
            move = plain_move(ps2_out);
        end
        EXT: begin
          if (ps2_out == SC_BRK) begin
            state_nxt = EXT_BRK;
          end else begin
            state_nxt = IDLE;
`ifdef ARROW_KEYS_EN
            move = arrow_move(ps2_out);
`endif
          end
        end
        BRK, EXT_BRK: state_nxt = IDLE;
      endcase
    end
  end

  // Prefix state register.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) state <= IDLE;
    else         state <= state_nxt;
  end

  // Shadow position, saturating at the screen edges.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      sx <= XINIT;
      sy <= YINIT;
    end else begin
      case (move)
        MV_LEFT:  sx <= sat_sub(sx, STP);
        MV_RIGHT: sx <= sat_add(sx, STP, XMAX);
        MV_UP:    sy <= sat_sub(sy, STP);
        MV_DOWN:  sy <= sat_add(sy, STP, YMAX);
        default:  ;
      endcase
    end
  end

  assign vs_fall = vs_q & ~iVS;

  // Commit the shadow at vsync start so a frame never sees a torn sprite.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      vs_q    <= 1'b0;
      oX      <= XINIT;
      oY      <= YINIT;
      oUpdate <= 1'b0;
    end else begin
      vs_q    <= iVS;
      oUpdate <= 1'b0;
      if (vs_fall) begin
        oX      <= sx;
        oY      <= sy;
        oUpdate <= (sx != oX) || (sy != oY);
      end
    end
  end

endmodule

// File: tb/tb_ps2_sprite_mover.sv
// Scoreboard bench: a behavioural key/position model queues expected commits.
// A monitor pops one entry per oUpdate pulse; stimulus checks held positions.
module tb_ps2_sprite_mover;

  typedef struct {
    int x;
    int y;
  } pos_t;

  logic       clk;
  logic       rst_n;
  logic       key;
  logic [7:0] code;
  logic       vs;
  logic [9:0] ox;
  logic [9:0] oy;
  logic       upd;

  int   total;
  int   bad;
  pos_t exp_q[$];

  int   mx;
  int   my;
  int   cx;
  int   cy;
  bit   m_ext;
  bit   m_brk;

  ps2_sprite_mover dut (
    .iVGA_CLK        (clk),
    .iRST_n          (rst_n),
    .ps2_key_pressed (key),
    .ps2_out         (code),
    .iVS             (vs),
    .oX              (ox),
    .oY              (oy),
    .oUpdate         (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && upd) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL update_unexpected got=(%0d,%0d) want=no pulse",
                 ox, oy);
      end else begin
        pos_t e;
        e = exp_q.pop_front();
        if (ox !== e.x || oy !== e.y) begin
          bad++;
          $display("FAIL update_pos got=(%0d,%0d) want=(%0d,%0d)",
                   ox, oy, e.x, e.y);
        end
      end
    end
  end

  function automatic int dir_plain(input logic [7:0] b);
    case (b)
      8'h1C:   return 1;
      8'h23:   return 2;
      8'h1D:   return 3;
      8'h1B:   return 4;
      default: return 0;
    endcase
  endfunction

  function automatic int dir_arrow(input logic [7:0] b);
    case (b)
      8'h6B:   return 1;
      8'h74:   return 2;
      8'h75:   return 3;
      8'h72:   return 4;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    mx = 340; my = 200;
    cx = 340; cy = 200;
    m_ext = 0; m_brk = 0;
    exp_q.delete();
  endtask

  task automatic model_byte(input logic [7:0] b);
    int d;
    d = 0;
    if (m_brk) begin
      m_brk = 0;
      m_ext = 0;
    end else if (b == 8'hF0) begin
      m_brk = 1;
    end else if (b == 8'hE0 && !m_ext) begin
      m_ext = 1;
    end else begin
      if (!m_ext) d = dir_plain(b);
`ifdef ARROW_KEYS_EN
      else d = dir_arrow(b);
`endif
      m_ext = 0;
      case (d)
        1: mx = (mx < 15) ? 0 : mx - 15;
        2: mx = (mx + 15 > 610) ? 610 : mx + 15;
        3: my = (my < 15) ? 0 : my - 15;
        4: my = (my + 15 > 450) ? 450 : my + 15;
        default: ;
      endcase
    end
  endtask

  task automatic model_commit();
    pos_t e;
    if (mx != cx || my != cy) begin
      e.x = mx;
      e.y = my;
      exp_q.push_back(e);
    end
    cx = mx;
    cy = my;
  endtask

  task automatic check_pos(input string name);
    @(negedge clk);
    total++;
    if (ox !== cx || oy !== cy) begin
      bad++;
      $display("FAIL %s got=(%0d,%0d) want=(%0d,%0d)",
               name, ox, oy, cx, cy);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk);
    #1 code = b; key = 1'b1;
    repeat (4) @(posedge clk);
    #1 key = 1'b0;
    repeat (3) @(posedge clk);
    model_byte(b);
  endtask

  task automatic do_frame(input string name);
    @(posedge clk);
    #1 vs = 1'b0;
    model_commit();
    repeat (3) @(posedge clk);
    #1 vs = 1'b1;
    repeat (2) @(posedge clk);
    check_pos(name);
  endtask

  task automatic pulse_reset();
    #3 rst_n = 1'b0;
    key = 1'b0;
    vs  = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    key   = 1'b0;
    code  = 8'h00;
    vs    = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    check_pos("reset_pos");
    total++;
    if (upd !== 1'b0) begin
      bad++;
      $display("FAIL reset_upd got=%0b want=0", upd);
    end
    do_frame("idle_frame1");
    do_frame("idle_frame2");

    send_byte(8'h23);
    check_pos("hold_before_vs");
    do_frame("right_one");

    send_byte(8'hF0);
    send_byte(8'h23);
    do_frame("break_no_move");
    send_byte(8'h23);
    do_frame("idle_after_break");

    for (int i = 0; i < 30; i++) send_byte(8'h1C);
    do_frame("left_saturate");

    for (int i = 0; i < 40; i++) send_byte(8'h1B);
    do_frame("down_saturate");

    for (int i = 0; i < 5; i++) send_byte(8'h23);
    do_frame("right_5");
    send_byte(8'hE0);
    send_byte(8'h6B);
    do_frame("ext_left");

    send_byte(8'hE0);
    send_byte(8'hF0);
    send_byte(8'h6B);
    do_frame("ext_break");

    // byte_vld lands in the same cycle as the vsync fall
    @(posedge clk);
    #1 code = 8'h23; key = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 vs = 1'b0;
    model_commit();
    model_byte(8'h23);
    repeat (3) @(posedge clk);
    #1 key = 1'b0; vs = 1'b1;
    repeat (3) @(posedge clk);
    check_pos("same_cycle_old");
    do_frame("same_cycle_new");

    send_byte(8'hE0);
    pulse_reset();
    check_pos("reset_mid_seq");
    send_byte(8'h6B);
    do_frame("plain_6b_after_reset");

    for (int i = 0; i < 300; i++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 9);
      case (r)
        0: b = 8'h1C;
        1: b = 8'h23;
        2: b = 8'h1D;
        3: b = 8'h1B;
        4: b = 8'hE0;
        5: b = 8'hF0;
        6, 7: begin
          case ($urandom_range(0, 3))
            0:       b = 8'h6B;
            1:       b = 8'h74;
            2:       b = 8'h75;
            default: b = 8'h72;
          endcase
        end
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (r == 9) do_frame("rand_frame");
      else        send_byte(b);
    end
    do_frame("rand_final");

    repeat (4) @(posedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_updates got=%0d pending want=0",
               exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
